// File: rtl/ldpc_shuffle_ctrl.sv
// Command front end for the 3-stage barrel-rotate network: FIFO, issue, shift decomposition.
// Optional sticky range flag guarded by LDPC_SHUFFLE_RANGE_CHECK_EN.
module ldpc_shuffle_ctrl #(
  parameter int FOLDFACTOR     = 4,
  parameter int NUMINSTANCES   = 360/FOLDFACTOR,
  parameter int LASTSHIFTWIDTH = 3,
  parameter int LASTSHIFTDIST  = 6,
  parameter int SHIFTWIDTH     = 7,
  parameter int TAGWIDTH       = 8,
  parameter int FIFODEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SHIFTWIDTH-1:0]     cmd_shift,
  input  logic                      cmd_first_half,
  input  logic [TAGWIDTH-1:0]       cmd_tag,
  input  logic                      hold,
  output logic                      first_half,
  output logic [1:0]                shift0,
  output logic [2:0]                shift1,
  output logic [LASTSHIFTWIDTH-1:0] shift2,
  output logic                      sh_valid,
  output logic [TAGWIDTH-1:0]       sh_tag,
  output logic                      busy,
  output logic                      range_err
);
  localparam int SHIFT0_MULT = (FOLDFACTOR == 1) ? 90 : (FOLDFACTOR == 2) ? 45 :
                               (FOLDFACTOR == 3) ? 30 : 23;
  localparam int SHIFT1_MULT = (FOLDFACTOR == 1) ? 12 : (FOLDFACTOR == 2) ? 6 :
                               (FOLDFACTOR == 3) ? 4 : 3;
  localparam int PW = $clog2(FIFODEPTH);
  localparam int CW = PW + 1;
  localparam logic [SHIFTWIDTH-1:0] NUM_C = SHIFTWIDTH'(NUMINSTANCES);

  typedef struct packed {
    logic [SHIFTWIDTH-1:0] shift;
    logic                  first_half;
    logic [TAGWIDTH-1:0]   tag;
  } cmd_t;

  cmd_t                      mem_q [FIFODEPTH];
  cmd_t                      mem_d [FIFODEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [2:0]                vld_pipe_q, vld_pipe_d;
  logic                      first_half_q, first_half_d;
  logic [1:0]                shift0_q, shift0_d;
  logic [2:0]                shift1_q, shift1_d;
  logic [LASTSHIFTWIDTH-1:0] shift2_q, shift2_d;
  logic [2:0]                p0_q1_q, p0_q1_d;
  logic [LASTSHIFTWIDTH-1:0] p0_q2_q, p0_q2_d, p1_q2_q, p1_q2_d;
  logic [TAGWIDTH-1:0]       p0_tag_q, p0_tag_d, p1_tag_q, p1_tag_d, p2_tag_q, p2_tag_d;
  logic                      sh_valid_q, sh_valid_d;
  logic [TAGWIDTH-1:0]       sh_tag_q, sh_tag_d;
  logic                      busy_q, busy_d;

  cmd_t                      head;
  logic                      wr_en, pop, wrap;
  logic [SHIFTWIDTH-1:0]     s, r, off0, off1;
  logic [1:0]                q0;
  logic [2:0]                q1;
  logic [LASTSHIFTWIDTH-1:0] q2;

  assign cmd_ready = (count_q != CW'(FIFODEPTH));
  assign wr_en     = cmd_valid && cmd_ready;
  assign pop       = (count_q != '0) && !hold;
  assign head      = mem_q[rd_ptr_q];

  // Decompose the FIFO head with constant compares; the largest threshold met wins.
  always_comb begin
    wrap = (head.shift >= NUM_C);
    s    = wrap ? head.shift - NUM_C : head.shift;
    q0   = '0;
    off0 = '0;
    for (int k = 1; k <= 3; k++) begin
      if (s >= SHIFTWIDTH'(k*SHIFT0_MULT)) begin
        q0   = 2'(k);
        off0 = SHIFTWIDTH'(k*SHIFT0_MULT);
      end
    end
    r    = s - off0;
    q1   = '0;
    off1 = '0;
    for (int k = 1; k <= 7; k++) begin
      if (r >= SHIFTWIDTH'(k*SHIFT1_MULT)) begin
        q1   = 3'(k);
        off1 = SHIFTWIDTH'(k*SHIFT1_MULT);
      end
    end
    q2 = LASTSHIFTWIDTH'(r - off1);
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    first_half_d = first_half_q;
    shift0_d     = shift0_q;
    shift1_d     = shift1_q;
    shift2_d     = shift2_q;
    p0_q1_d      = p0_q1_q;
    p0_q2_d      = p0_q2_q;
    p1_q2_d      = p1_q2_q;
    p0_tag_d     = p0_tag_q;
    p1_tag_d     = p1_tag_q;
    p2_tag_d     = p2_tag_q;
    sh_tag_d     = sh_tag_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = '{shift: cmd_shift, first_half: cmd_first_half, tag: cmd_tag};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    vld_pipe_d = {vld_pipe_q[1:0], pop};
    // Each select only moves when its stage carries a command; otherwise it holds.
    if (pop) begin
      shift0_d     = q0;
      first_half_d = head.first_half;
      p0_q1_d      = q1;
      p0_q2_d      = q2;
      p0_tag_d     = head.tag;
    end
    if (vld_pipe_q[0]) begin
      shift1_d = p0_q1_q;
      p1_q2_d  = p0_q2_q;
      p1_tag_d = p0_tag_q;
    end
    if (vld_pipe_q[1]) begin
      shift2_d = p1_q2_q;
      p2_tag_d = p1_tag_q;
    end
    sh_valid_d = vld_pipe_q[2];
    if (vld_pipe_q[2]) sh_tag_d = p2_tag_q;
    busy_d = (count_q != '0) || (|vld_pipe_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFODEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      vld_pipe_q   <= '0;
      first_half_q <= 1'b0;
      shift0_q     <= '0;
      shift1_q     <= '0;
      shift2_q     <= '0;
      p0_q1_q      <= '0;
      p0_q2_q      <= '0;
      p1_q2_q      <= '0;
      p0_tag_q     <= '0;
      p1_tag_q     <= '0;
      p2_tag_q     <= '0;
      sh_valid_q   <= 1'b0;
      sh_tag_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      vld_pipe_q   <= vld_pipe_d;
      first_half_q <= first_half_d;
      shift0_q     <= shift0_d;
      shift1_q     <= shift1_d;
      shift2_q     <= shift2_d;
      p0_q1_q      <= p0_q1_d;
      p0_q2_q      <= p0_q2_d;
      p1_q2_q      <= p1_q2_d;
      p0_tag_q     <= p0_tag_d;
      p1_tag_q     <= p1_tag_d;
      p2_tag_q     <= p2_tag_d;
      sh_valid_q   <= sh_valid_d;
      sh_tag_q     <= sh_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign first_half = first_half_q;
  assign shift0     = shift0_q;
  assign shift1     = shift1_q;
  assign shift2     = shift2_q;
  assign sh_valid   = sh_valid_q;
  assign sh_tag     = sh_tag_q;
  assign busy       = busy_q;

`ifdef LDPC_SHUFFLE_RANGE_CHECK_EN
  logic                  range_err_q, range_err_d;
  logic [SHIFTWIDTH-1:0] fine_full;

  // Flag is sticky; the command itself still runs with reduced/clamped selects.
  always_comb begin
    fine_full   = r - off1;
    range_err_d = range_err_q;
    if (pop && (wrap || (fine_full > SHIFTWIDTH'(LASTSHIFTDIST)))) range_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_ldpc_shuffle_ctrl.sv
// Directed bench for ldpc_shuffle_ctrl: staged selects, back-to-back issue, hold, range flag, reset flush.
module tb_ldpc_shuffle_ctrl;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_first_half, hold;
  logic [6:0] cmd_shift;
  logic [7:0] cmd_tag, sh_tag;
  logic       first_half, sh_valid, busy, range_err;
  logic [1:0] shift0;
  logic [2:0] shift1, shift2;

  int vectors = 0;
  int errs    = 0;

`ifdef LDPC_SHUFFLE_RANGE_CHECK_EN
  localparam logic EXP_RE = 1'b1;
`else
  localparam logic EXP_RE = 1'b0;
`endif

  ldpc_shuffle_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shift(cmd_shift), .cmd_first_half(cmd_first_half), .cmd_tag(cmd_tag),
    .hold(hold), .first_half(first_half), .shift0(shift0), .shift1(shift1),
    .shift2(shift2), .sh_valid(sh_valid), .sh_tag(sh_tag), .busy(busy),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".cmd_ready"}, cmd_ready, 1);
    chk({nm, ".first_half"}, first_half, 0);
    chk({nm, ".shift0"}, shift0, 0);
    chk({nm, ".shift1"}, shift1, 0);
    chk({nm, ".shift2"}, shift2, 0);
    chk({nm, ".sh_valid"}, sh_valid, 0);
    chk({nm, ".sh_tag"}, sh_tag, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".range_err"}, range_err, 0);
  endtask

  // One isolated command: write, pop next cycle (T), then walk the stages.
  task automatic run_one(input string nm, input logic [6:0] sh, input logic fh,
                         input logic [7:0] tg, input logic [1:0] e0,
                         input logic [2:0] e1, input logic [2:0] e2);
    cmd_valid = 1; cmd_shift = sh; cmd_first_half = fh; cmd_tag = tg;
    tick();
    cmd_valid = 0;
    tick();
    chk({nm, ".T.shift0"}, shift0, e0);
    chk({nm, ".T.first_half"}, first_half, fh);
    chk({nm, ".T.sh_valid"}, sh_valid, 0);
    tick();
    chk({nm, ".T1.shift1"}, shift1, e1);
    chk({nm, ".T1.shift0_hold"}, shift0, e0);
    tick();
    chk({nm, ".T2.shift2"}, shift2, e2);
    tick();
    chk({nm, ".T3.sh_valid"}, sh_valid, 1);
    chk({nm, ".T3.sh_tag"}, sh_tag, tg);
    chk({nm, ".T3.busy"}, busy, 1);
    tick();
    chk({nm, ".T4.sh_valid"}, sh_valid, 0);
    chk({nm, ".T4.busy"}, busy, 0);
    chk({nm, ".T4.shift2_hold"}, shift2, e2);
  endtask

  logic [6:0] hs_sh [5] = '{7'd89, 7'd50, 7'd22, 7'd60, 7'd10};
  logic [1:0] hs_q0 [4] = '{2'd3, 2'd2, 2'd0, 2'd2};
  logic [2:0] hs_q1 [4] = '{3'd6, 3'd1, 3'd7, 3'd4};
  logic [2:0] hs_q2 [4] = '{3'd2, 3'd1, 3'd1, 3'd2};

  initial begin
    rst = 1; cmd_valid = 0; cmd_shift = 0; cmd_first_half = 0; cmd_tag = 0; hold = 0;
    tick(); tick();
    rst = 0;
    chk_reset_vals("reset");

    run_one("s0",   7'd0,  1'b1, 8'h11, 2'd0, 3'd0, 3'd2 - 3'd2);
    run_one("s89",  7'd89, 1'b0, 8'h22, 2'd3, 3'd6, 3'd2);
    run_one("s50",  7'd50, 1'b1, 8'h33, 2'd2, 3'd1, 3'd1);
    run_one("s22",  7'd22, 1'b0, 8'h44, 2'd0, 3'd7, 3'd1);
    chk("legal.range_err", range_err, 0);

    run_one("s95",  7'd95, 1'b1, 8'h55, 2'd0, 3'd1, 3'd2);
    chk("s95.range_err", range_err, EXP_RE);
    run_one("s127", 7'd127, 1'b0, 8'h66, 2'd1, 3'd4, 3'd2);
    tick(); tick();
    chk("sticky.range_err", range_err, EXP_RE);

    // Fill under hold: the fifth offer must be refused.
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1; cmd_shift = hs_sh[i]; cmd_first_half = 1'(i); cmd_tag = 8'hA0 + 8'(i);
      chk($sformatf("fill%0d.cmd_ready", i), cmd_ready, (i < 4) ? 1 : 0);
      tick();
    end
    cmd_valid = 0;
    chk("full.cmd_ready", cmd_ready, 0);
    chk("full.busy", busy, 1);
    tick(); tick();
    chk("held.sh_valid", sh_valid, 0);
    hold = 0;
    tick();
    for (int c = 0; c < 8; c++) begin
      int i0, i1, i2;
      i0 = (c < 3) ? c : 3;
      i1 = (c - 1 < 3) ? c - 1 : 3;
      i2 = (c - 2 < 3) ? c - 2 : 3;
      chk($sformatf("b2b%0d.shift0", c), shift0, hs_q0[i0]);
      if (c >= 1) chk($sformatf("b2b%0d.shift1", c), shift1, hs_q1[i1]);
      if (c >= 2) chk($sformatf("b2b%0d.shift2", c), shift2, hs_q2[i2]);
      chk($sformatf("b2b%0d.sh_valid", c), sh_valid, (c >= 3 && c <= 6) ? 1 : 0);
      if (c >= 3 && c <= 6) chk($sformatf("b2b%0d.sh_tag", c), sh_tag, 8'hA0 + 8'(c - 3));
      chk($sformatf("b2b%0d.busy", c), busy, (c <= 6) ? 1 : 0);
      chk($sformatf("b2b%0d.cmd_ready", c), cmd_ready, 1);
      tick();
    end
    chk("b2b.range_err", range_err, EXP_RE);

    // Reset with two commands in flight and two buffered.
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1; cmd_shift = 7'd30 + 7'(i); cmd_first_half = 1; cmd_tag = 8'hB0 + 8'(i);
      tick();
    end
    cmd_valid = 0;
    hold = 0;
    tick();
    tick();
    chk("pre_rst.cmd_ready", cmd_ready, 1);
    chk("pre_rst.busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk_reset_vals("midrst");
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("flush%0d.sh_valid", c), sh_valid, 0);
      chk($sformatf("flush%0d.busy", c), busy, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ldpc_shuffle_ctrl.md
Name: ldpc_shuffle_ctrl

Overview:
- Command front end for the 3-stage barrel-rotate network. It accepts rotate commands: shift amount, vn/cn source select and a tag.
- Commands are buffered in a small FIFO and issued one per cycle, subject to a hold input.
- Each shift amount is decomposed into the quarter/eighth/fine selects. Each select is presented in the cycle its pipeline stage samples it.
- A valid+tag is delivered aligned with the rotated output, 3 cycles after issue.

Parameters:
FOLDFACTOR, 4, fold factor; sets the stage multipliers SHIFT0_MULT/SHIFT1_MULT = 90/12, 45/6, 30/4, 23/3 for fold 1..4.
NUMINSTANCES, 360/FOLDFACTOR, rotation modulus.
LASTSHIFTWIDTH, 3, width of the fine-stage select.
LASTSHIFTDIST, 6, maximum legal fine-stage shift.
SHIFTWIDTH, 7, width of the command shift field.
TAGWIDTH, 8, width of the user tag carried alongside.
FIFODEPTH, 4, command FIFO entries (power of 2, >=2).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (not full)
cmd_shift  in  SHIFTWIDTH  rotate distance
cmd_first_half  in  1  1=vn messages, 0=cn messages
cmd_tag  in  TAGWIDTH  opaque tag
hold  in  1  1=do not issue this cycle
first_half  out  1  source select for stage 0
shift0  out  2  quarter-step select (stage 0)
shift1  out  3  eighth-step select (stage 1)
shift2  out  LASTSHIFTWIDTH  fine select (stage 2)
sh_valid  out  1  rotated data valid this cycle
sh_tag  out  TAGWIDTH  tag of the rotated data
busy  out  1  FIFO non-empty or any command in flight
range_err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - FIFO is emptied; cmd_ready=1.
  - first_half=0; shift0/shift1/shift2=0.
  - sh_valid=0; sh_tag=0; busy=0; range_err=0.
- Reset mid-operation flushes the FIFO and all in-flight stages. No sh_valid is produced for flushed commands.
- Handshake: a write occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full. It is combinational from the FIFO count only.
  - A simultaneous write and pop when full is not accepted; ready is low, so no write occurs.
  - A write into an empty FIFO may be popped no earlier than the next cycle.
- Issue: the FIFO is popped when it is non-empty && !hold. The popped entry is loaded into the issue register at the clock edge (cycle T = first cycle it is visible).
- Decomposition, with s reduced to the range 0..NUMINSTANCES-1:
  - q0 = min(floor(s/SHIFT0_MULT), 3)
  - r = s - q0*SHIFT0_MULT
  - q1 = min(floor(r/SHIFT1_MULT), 7)
  - q2 = r - q1*SHIFT1_MULT
  - Implement with constant compares; no divider.
- Reduction: if cmd_shift >= NUMINSTANCES, s = cmd_shift - NUMINSTANCES, applied once. Since 2*NUMINSTANCES > 2^SHIFTWIDTH for the defaults, a single subtraction always suffices.
- Stage timing:
  - Cycle T: shift0=q0 and first_half.
  - Cycle T+1: shift1=q1.
  - Cycle T+2: shift2=q2.
  - Cycle T+3: sh_valid=1 with sh_tag.
- Idle cycles: in any cycle with no command at a given stage, that stage's select holds its last value. sh_valid=0 in those cycles.
- Throughput: back-to-back issue at 1/cycle. Up to 3 commands are in flight plus FIFODEPTH buffered.
- hold: stops only popping. In-flight commands still complete on schedule.
- busy = FIFO count != 0 || any of the 3 stage-valid bits set.

Optional Feature:
- Macro LDPC_SHUFFLE_RANGE_CHECK_EN.
- Defined:
  - range_err sets (sticky until rst) when an issued command has cmd_shift >= NUMINSTANCES.
  - range_err also sets if the computed q2 > LASTSHIFTDIST.
  - The command is still executed with the reduced/clamped values.
- Undefined: the check logic is absent and range_err is tied 0. Reduction behaviour is identical.

Test Plan:
- Defaults, write shift=0 tag=0x11 first_half=1 -> shift0=0 at T, shift1=0 at T+1, shift2=0 at T+2, sh_valid=1 sh_tag=0x11 at T+3.
- shift=89 -> q0=3, q1=6, q2=2. shift=50 -> 2/1/1. shift=22 -> 0/7/1. Each select appears in its staged cycle.
- Four back-to-back commands, hold=0 -> four consecutive sh_valid pulses at T+3..T+6, tags in write order.
- hold=1, write 5 commands -> cmd_ready drops after the 4th, 5th not accepted. Release hold -> 4 outputs in order, busy drops 1 cycle after the last sh_valid.
- shift=95 with RANGE_CHECK_EN -> executes as 5 (0/1/2), range_err=1 and stays 1. Without the macro -> same selects, range_err=0.
- rst asserted at T+1 with 2 commands in flight and 2 buffered -> no sh_valid afterwards, all outputs at reset values, cmd_ready=1 next cycle.
